iq_dac_formatter: RTL and testbench

Parametrised output stage between the burst controller and the baseband DACs. It accepts two's-complement I/Q samples and applies an amplitude ramp at burst start and end. It then rounds, saturates and converts them to offset-binary DAC codes of configurable width. It drives either two DACs in parallel or one DAC with I/Q interleaved, and owns the RF-chain enable including its turn-off guard time.

---
 rtl/iq_dac_formatter.sv | 331 +++++++++++++++++++++++++++++++++
 tb/tb_iq_dac_formatter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_dac_formatter.sv
// ---------------------------------------------------------------------------
// iq_dac_formatter
//
// Output stage between the burst controller and the baseband DACs. Takes
// two's-complement I/Q samples, applies an amplitude ramp at burst start and
// end, rounds and saturates to OUT_W bits and emits offset-binary DAC codes.
// Drives two DACs in parallel (dual mode) or one DAC with I/Q interleaved,
// and owns the RF-chain enable including its turn-off guard time.
//
// Build option: define DAC_RAMP_EN to build the ramped state machine. Without
// it the gain is fixed at unity, no multiplier is built, and bursts go
// straight IDLE -> ACTIVE -> GUARD.
//
// Ports:
//   clock         system clock, rising edge
//   reset_n       asynchronous active-low reset
//   iq_valid_i    a valid sample is presented this clock
//   inphase_i     I sample (two's complement, IN_W bits)
//   quadrature_i  Q sample (two's complement, IN_W bits)
//   interleave_i  0 = dual DAC, 1 = single DAC interleaved (latched in IDLE)
//   dac_a_o       I code (dual) or alternating I/Q code (interleaved)
//   dac_b_o       Q code (dual) or midscale (interleaved)
//   dac_sel_o     interleaved: 0 = dac_a_o carries I, 1 = carries Q
//   txchain_en_o  RF-chain enable
//   busy_o        high whenever the block is not IDLE
// ---------------------------------------------------------------------------
module iq_dac_formatter #(
    parameter int IN_W     = 9,
    parameter int OUT_W    = 6,
    parameter int RAMP_LEN = 16,
    parameter int GUARD    = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             iq_valid_i,
    input  logic [IN_W-1:0]  inphase_i,
    input  logic [IN_W-1:0]  quadrature_i,
    input  logic             interleave_i,
    output logic [OUT_W-1:0] dac_a_o,
    output logic [OUT_W-1:0] dac_b_o,
    output logic             dac_sel_o,
    output logic             txchain_en_o,
    output logic             busy_o
);

    localparam int LG = $clog2(RAMP_LEN);
    localparam int SH = IN_W - OUT_W;
    localparam int PW = IN_W + LG + 2;
    localparam int CW = (GUARD > 1) ? $clog2(GUARD) : 1;
    localparam logic [OUT_W-1:0]     MID    = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic signed [PW-1:0] HALF_C = PW'(2 ** (SH - 1));
    localparam logic signed [PW-1:0] MAX_C  = PW'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [PW-1:0] MIN_C  = PW'(-(2 ** (OUT_W - 1)));
`ifdef DAC_RAMP_EN
    localparam int GW = LG + 1;
`endif

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RAMP_UP   = 3'd1,
        S_ACTIVE    = 3'd2,
        S_RAMP_DOWN = 3'd3,
        S_GUARD     = 3'd4
    } state_t;

    // Round half-up, saturate, and flip the MSB to get offset binary.
    function automatic logic [OUT_W-1:0] sat_conv(input logic signed [PW-1:0] scaled);
        logic signed [PW-1:0] r;
        r = (scaled + HALF_C) >>> SH;
        if (r > MAX_C) begin
            r = MAX_C;
        end else if (r < MIN_C) begin
            r = MIN_C;
        end else begin
            r = r;
        end
        return r[OUT_W-1:0] ^ MID;
    endfunction

`ifdef DAC_RAMP_EN
    // Full-precision product, then divide by RAMP_LEN with an arithmetic shift.
    function automatic logic [OUT_W-1:0] dac_code(input logic [IN_W-1:0] s,
                                                  input logic [GW-1:0] g);
        logic signed [PW-1:0] acc;
        acc = $signed({{(PW-IN_W){s[IN_W-1]}}, s}) * $signed({{(PW-GW){1'b0}}, g});
        acc = acc >>> LG;
        return sat_conv(acc);
    endfunction
`else
    function automatic logic [OUT_W-1:0] dac_code(input logic [IN_W-1:0] s);
        logic signed [PW-1:0] acc;
        acc = $signed({{(PW-IN_W){s[IN_W-1]}}, s});
        return sat_conv(acc);
    endfunction
`endif

    state_t            state_q, state_d;
    logic [CW-1:0]     gcnt_q, gcnt_d;
    logic              mode_q, mode_d;
    logic              phase_q, phase_d;
    logic [IN_W-1:0]   held_i_q, held_i_d, held_q_q, held_q_d;
    logic              accept_s, emit_s;
    logic [IN_W-1:0]   s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic              s1_sel_q, s1_sel_d;
    logic [OUT_W-1:0]  dac_a_q, dac_b_q;
    logic              dac_sel_q, txen_q, busy_q;
`ifdef DAC_RAMP_EN
    logic [GW-1:0]     g_q, g_d, s1_g_q, s1_g_d;
`endif

    // Burst state machine; decisions are taken only on the first half of a pair.
    always_comb begin
        state_d  = state_q;
        gcnt_d   = gcnt_q;
        mode_d   = mode_q;
        accept_s = 1'b0;
        emit_s   = 1'b0;
`ifdef DAC_RAMP_EN
        g_d      = g_q;
`endif
        if (phase_q) begin
            state_d = state_q;
        end else begin
`ifdef DAC_RAMP_EN
            case (state_q)
                S_IDLE: begin
                    if (iq_valid_i) begin
                        mode_d   = interleave_i;
                        accept_s = 1'b1;
                        emit_s   = 1'b1;
                        g_d      = GW'(1);
                        state_d  = S_RAMP_UP;
                    end else begin
                        g_d = '0;
                    end
                end
                S_RAMP_UP: begin
                    emit_s = 1'b1;
                    if (iq_valid_i) begin
                        accept_s = 1'b1;
                        g_d      = g_q + GW'(1);
                        state_d  = (g_q + GW'(1) == GW'(RAMP_LEN)) ? S_ACTIVE : S_RAMP_UP;
                    end else begin
                        g_d     = g_q - GW'(1);
                        state_d = S_RAMP_DOWN;
                    end
                end
                S_ACTIVE: begin
                    emit_s = 1'b1;
                    if (iq_valid_i) begin
                        accept_s = 1'b1;
                    end else begin
                        g_d     = GW'(RAMP_LEN - 1);
                        state_d = S_RAMP_DOWN;
                    end
                end
                S_RAMP_DOWN: begin
                    if (iq_valid_i) begin
                        accept_s = 1'b1;
                        emit_s   = 1'b1;
                        g_d      = g_q + GW'(1);
                        state_d  = (g_q + GW'(1) == GW'(RAMP_LEN)) ? S_ACTIVE : S_RAMP_UP;
                    end else if (g_q == '0) begin
                        gcnt_d  = '0;
                        state_d = S_GUARD;
                    end else begin
                        emit_s = 1'b1;
                        g_d    = g_q - GW'(1);
                    end
                end
                S_GUARD: begin
                    if (iq_valid_i) begin
                        accept_s = 1'b1;
                        emit_s   = 1'b1;
                        g_d      = GW'(1);
                        gcnt_d   = '0;
                        state_d  = S_RAMP_UP;
                    end else if (gcnt_q == CW'(GUARD - 1)) begin
                        gcnt_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        gcnt_d = gcnt_q + CW'(1);
                    end
                end
                default: begin
                    g_d     = '0;
                    state_d = S_IDLE;
                end
            endcase
`else
            case (state_q)
                S_IDLE: begin
                    if (iq_valid_i) begin
                        mode_d   = interleave_i;
                        accept_s = 1'b1;
                        emit_s   = 1'b1;
                        state_d  = S_ACTIVE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_ACTIVE: begin
                    if (iq_valid_i) begin
                        accept_s = 1'b1;
                        emit_s   = 1'b1;
                    end else begin
                        gcnt_d  = '0;
                        state_d = S_GUARD;
                    end
                end
                S_GUARD: begin
                    if (iq_valid_i) begin
                        accept_s = 1'b1;
                        emit_s   = 1'b1;
                        gcnt_d   = '0;
                        state_d  = S_ACTIVE;
                    end else if (gcnt_q == CW'(GUARD - 1)) begin
                        gcnt_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        gcnt_d = gcnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
`endif
        end
    end

    // Held sample: the last accepted pair, reused for ramp-down and the Q half.
    always_comb begin
        if (accept_s) begin
            held_i_d = inphase_i;
            held_q_d = quadrature_i;
        end else begin
            held_i_d = held_i_q;
            held_q_d = held_q_q;
        end
    end

    // Stage-1 operands; a zero sample yields midscale at any gain.
    always_comb begin
        phase_d  = 1'b0;
        s1_a_d   = '0;
        s1_b_d   = '0;
        s1_sel_d = 1'b0;
`ifdef DAC_RAMP_EN
        s1_g_d   = '0;
`endif
        if (phase_q) begin
            s1_a_d   = held_q_q;
            s1_sel_d = 1'b1;
`ifdef DAC_RAMP_EN
            s1_g_d   = g_q;
`endif
        end else if (emit_s) begin
            s1_a_d  = held_i_d;
            s1_b_d  = mode_d ? '0 : held_q_d;
            phase_d = mode_d;
`ifdef DAC_RAMP_EN
            s1_g_d  = g_d;
`endif
        end else begin
            phase_d = 1'b0;
        end
    end

    // Control state and stage-1 pipeline registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            gcnt_q   <= '0;
            mode_q   <= 1'b0;
            phase_q  <= 1'b0;
            held_i_q <= '0;
            held_q_q <= '0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s1_sel_q <= 1'b0;
            txen_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef DAC_RAMP_EN
            g_q      <= '0;
            s1_g_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            gcnt_q   <= gcnt_d;
            mode_q   <= mode_d;
            phase_q  <= phase_d;
            held_i_q <= held_i_d;
            held_q_q <= held_q_d;
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
            s1_sel_q <= s1_sel_d;
            txen_q   <= (state_d != S_IDLE);
            busy_q   <= (state_d != S_IDLE);
`ifdef DAC_RAMP_EN
            g_q      <= g_d;
            s1_g_q   <= s1_g_d;
`endif
        end
    end

    // Stage-2: scaled, rounded, saturated offset-binary DAC codes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dac_a_q   <= MID;
            dac_b_q   <= MID;
            dac_sel_q <= 1'b0;
        end else begin
`ifdef DAC_RAMP_EN
            dac_a_q   <= dac_code(s1_a_q, s1_g_q);
            dac_b_q   <= dac_code(s1_b_q, s1_g_q);
`else
            dac_a_q   <= dac_code(s1_a_q);
            dac_b_q   <= dac_code(s1_b_q);
`endif
            dac_sel_q <= s1_sel_q;
        end
    end

    assign dac_a_o      = dac_a_q;
    assign dac_b_o      = dac_b_q;
    assign dac_sel_o    = dac_sel_q;
    assign txchain_en_o = txen_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_iq_dac_formatter.sv
// Testbench for iq_dac_formatter: burst-level reference model plus directed
// literal checks; works with or without DAC_RAMP_EN.
module tb_iq_dac_formatter;

    localparam int IN_W     = 9;
    localparam int OUT_W    = 6;
    localparam int RAMP_LEN = 16;
    localparam int GUARD    = 4;
    localparam int MIDV     = 2 ** (OUT_W - 1);
`ifdef DAC_RAMP_EN
    localparam bit RAMP = 1'b1;
`else
    localparam bit RAMP = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset_n;
    logic             iq_valid_i;
    logic [IN_W-1:0]  inphase_i;
    logic [IN_W-1:0]  quadrature_i;
    logic             interleave_i;
    logic [OUT_W-1:0] dac_a_o;
    logic [OUT_W-1:0] dac_b_o;
    logic             dac_sel_o;
    logic             txchain_en_o;
    logic             busy_o;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    // model state
    int m_on, m_gain, m_guard, m_pend, m_mode, m_hi, m_hq;
    int e1_a, e1_b, e1_sel;          // code decided at the last edge
    int ex_a, ex_b, ex_sel, ex_tx;   // what the outputs must show now

    iq_dac_formatter #(.IN_W(IN_W), .OUT_W(OUT_W), .RAMP_LEN(RAMP_LEN), .GUARD(GUARD)) dut (
        .clock(clock), .reset_n(reset_n), .iq_valid_i(iq_valid_i),
        .inphase_i(inphase_i), .quadrature_i(quadrature_i), .interleave_i(interleave_i),
        .dac_a_o(dac_a_o), .dac_b_o(dac_b_o), .dac_sel_o(dac_sel_o),
        .txchain_en_o(txchain_en_o), .busy_o(busy_o)
    );

    always #5 clock = ~clock;

    function automatic int fdiv(input int a, input int b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    function automatic int code_of(input int s, input int g);
        int r;
        r = fdiv(fdiv(s * g, RAMP_LEN) + 2 ** (IN_W - OUT_W - 1), 2 ** (IN_W - OUT_W));
        if (r > MIDV - 1) r = MIDV - 1;
        if (r < -MIDV) r = -MIDV;
        return r + MIDV;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_on = 0; m_gain = 0; m_guard = 0; m_pend = 0; m_mode = 0; m_hi = 0; m_hq = 0;
        e1_a = MIDV; e1_b = MIDV; e1_sel = 0;
        ex_a = MIDV; ex_b = MIDV; ex_sel = 0; ex_tx = 0;
    endtask

    task automatic model_emit(input int i, input int q);
        e1_a = code_of(i, m_gain);
        e1_sel = 0;
        if (m_mode != 0) begin
            e1_b = MIDV;
            m_pend = 1;
        end else begin
            e1_b = code_of(q, m_gain);
        end
    endtask

    task automatic model_mid();
        e1_a = MIDV; e1_b = MIDV; e1_sel = 0;
    endtask

    // One clock edge of the burst-level behaviour.
    task automatic model_step(input bit v, input int i, input int q, input bit il);
        ex_a = e1_a; ex_b = e1_b; ex_sel = e1_sel;
        if (m_pend != 0) begin
            e1_a = code_of(m_hq, m_gain); e1_b = MIDV; e1_sel = 1;
            m_pend = 0;
        end else if (v) begin
            if (m_on == 0) begin
                m_mode = il;
                m_gain = 0;
            end
            m_on = 1;
            m_guard = 0;
            if (RAMP) m_gain = (m_gain < RAMP_LEN) ? m_gain + 1 : RAMP_LEN;
            else m_gain = RAMP_LEN;
            m_hi = i; m_hq = q;
            model_emit(i, q);
        end else if (m_on == 0) begin
            model_mid();
        end else if (m_guard > 0) begin
            m_guard--;
            if (m_guard == 0) m_on = 0;
            model_mid();
        end else if (RAMP && m_gain > 0) begin
            m_gain--;
            model_emit(m_hi, m_hq);
        end else begin
            m_gain = 0;
            m_guard = GUARD;
            model_mid();
        end
        ex_tx = m_on;
    endtask

    task automatic cycle(input bit v, input int i, input int q, input bit il);
        @(negedge clock);
        iq_valid_i = v;
        inphase_i = IN_W'(i);
        quadrature_i = IN_W'(q);
        interleave_i = il;
        @(posedge clock);
        #1;
        if (reset_n) model_step(v, i, q, il);
    endtask

    function automatic int rnd_sample();
        return int'($urandom_range(0, 511)) - 256;
    endfunction

    // Single compare process: DUT against the model every cycle.
    always @(negedge clock) begin
        if (check_en) begin
            check("dac_a", int'(dac_a_o), ex_a);
            check("dac_b", int'(dac_b_o), ex_b);
            check("dac_sel", int'(dac_sel_o), ex_sel);
            check("txchain_en", int'(txchain_en_o), ex_tx);
            check("busy", int'(busy_o), ex_tx);
        end
    end

    initial begin
        int cv[5];
        int ce[5];
        int len, gap;
        bit md;
        cv = '{-256, 0, 3, 4, 128};
        ce = '{0, 32, 32, 33, 48};

        reset_n = 1'b0; iq_valid_i = 1'b0; inphase_i = '0; quadrature_i = '0; interleave_i = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check("rst_dac_a", int'(dac_a_o), 32);
        check("rst_dac_b", int'(dac_b_o), 32);
        check("rst_txen", int'(txchain_en_o), 0);
        check("rst_busy", int'(busy_o), 0);
        @(negedge clock);
        reset_n = 1'b1;
        check_en = 1'b1;
        repeat (3) cycle(1'b0, 0, 0, 1'b0);

        // ramp-up on constant full-scale I, then conversion table at unity gain
        for (int k = 1; k <= 16; k++) begin
            cycle(1'b1, 255, -255, 1'b0);
            if (k == 1) check("txen_first_edge", int'(txchain_en_o), 1);
            if (k == 9) check("ramp_g8", int'(dac_a_o), RAMP ? 48 : 63);
        end
        cycle(1'b1, cv[0], 0, 1'b0);
        check("unity_255", int'(dac_a_o), 63);
        for (int j = 1; j < 5; j++) begin
            cycle(1'b1, cv[j], 0, 1'b0);
            check("conv", int'(dac_a_o), ce[j-1]);
        end
        cycle(1'b1, 255, 0, 1'b0);
        check("conv_128", int'(dac_a_o), ce[4]);
        cycle(1'b0, 0, 0, 1'b0);
        cycle(1'b0, 0, 0, 1'b0);
        check("rampdown_g15", int'(dac_a_o), RAMP ? 62 : 32);
        repeat (23) cycle(1'b0, 0, 0, 1'b0);
        check("end_txen", int'(txchain_en_o), 0);
        check("end_busy", int'(busy_o), 0);

        // abort after 5 ramp-up samples, retrigger during ramp-down
        repeat (5) cycle(1'b1, 255, 0, 1'b0);
        cycle(1'b0, 0, 0, 1'b0);
        cycle(1'b0, 0, 0, 1'b0);
        check("abort_g4", int'(dac_a_o), RAMP ? 40 : 32);
        cycle(1'b0, 0, 0, 1'b0);
        cycle(1'b1, 255, 0, 1'b0);
        check("retrig_txen", int'(txchain_en_o), 1);
        cycle(1'b1, 255, 0, 1'b0);
        check("retrig_g3", int'(dac_a_o), RAMP ? 38 : 63);
        repeat (45) cycle(1'b0, 0, 0, 1'b0);

        // interleaved I=+128, Q=-128
        for (int k = 1; k <= 40; k++) begin
            cycle(1'b1, 128, -128, 1'b1);
            if (k == 2) check("il_first_i", int'(dac_a_o), RAMP ? 33 : 48);
            if (k == 3) check("il_first_q", int'(dac_a_o), RAMP ? 31 : 16);
            if (k == 40) begin
                check("il_i", int'(dac_a_o), 48);
                check("il_sel0", int'(dac_sel_o), 0);
            end
        end
        cycle(1'b0, 0, 0, 1'b0);
        check("il_q", int'(dac_a_o), 16);
        check("il_sel1", int'(dac_sel_o), 1);
        check("il_b_mid", int'(dac_b_o), 32);
        repeat (50) cycle(1'b0, 0, 0, 1'b0);

        // asynchronous reset in the middle of ACTIVE
        repeat (20) cycle(1'b1, 255, 100, 1'b0);
        #2;
        check_en = 1'b0;
        reset_n = 1'b0;
        #1;
        check("arst_dac_a", int'(dac_a_o), 32);
        check("arst_dac_b", int'(dac_b_o), 32);
        check("arst_sel", int'(dac_sel_o), 0);
        check("arst_txen", int'(txchain_en_o), 0);
        check("arst_busy", int'(busy_o), 0);
        iq_valid_i = 1'b0;
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        check_en = 1'b1;

        // randomized bursts in both modes
        for (int b = 0; b < 30; b++) begin
            md = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 30));
            gap = int'($urandom_range(0, 24));
            for (int u = 0; u < len; u++) begin
                int si, sq;
                si = rnd_sample();
                sq = rnd_sample();
                cycle(1'b1, si, sq, (u == 0) ? md : 1'($urandom_range(0, 1)));
                if (md) cycle(1'b1, si, sq, 1'($urandom_range(0, 1)));
            end
            for (int u = 0; u < gap; u++) begin
                cycle(1'b0, rnd_sample(), rnd_sample(), 1'($urandom_range(0, 1)));
                if (md) cycle(1'b0, 0, 0, 1'($urandom_range(0, 1)));
            end
        end
        repeat (60) cycle(1'b0, 0, 0, 1'b0);

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
